// File: rtl/pcileech_bar_pkg.sv
// Shared types and helpers for the BAR register file:
// the register entry layout, the offset decode and the masked write merge.
package pcileech_bar_pkg;

  localparam int CTX_W = 88;

  typedef struct packed {
    logic [31:0] value;
    logic [31:0] shadow;
    logic [31:0] wmask;
    logic [31:0] w1cmask;
  } reg_entry_t;

  // Dword index of a BAR access; bit 2 of the BAR value is a type flag, not address.
  function automatic logic [29:0] bar_dword(input logic [31:0] addr,
                                            input logic [31:0] bar,
                                            input logic [31:0] mask);
    return 30'(((addr - (bar & ~32'h00000004)) & mask) >> 2);
  endfunction

  function automatic logic [31:0] merge_write(input logic [31:0] cur,
                                              input logic [31:0] wmask,
                                              input logic [31:0] w1cmask,
                                              input logic [3:0]  be,
                                              input logic [31:0] data);
    logic [31:0] lane;
    logic [31:0] plain;
    lane  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    plain = lane & wmask & ~w1cmask;
    return ((cur & ~plain) | (data & plain)) & ~(lane & w1cmask & data);
  endfunction

endpackage

// File: rtl/pcileech_bar_rdpipe.sv
// Fixed-depth valid/ctx/data delay line; data and ctx only move with a valid
// beat so the output holds its last response between beats.
module pcileech_bar_rdpipe
  import pcileech_bar_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CTX_W-1:0] in_ctx,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  output logic [CTX_W-1:0] out_ctx,
  output logic [31:0]      out_data
);

  logic [DEPTH-1:0] vld;
  logic [CTX_W-1:0] ctx [DEPTH];
  logic [31:0]      dat [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctx[i] <= '0;
        dat[i] <= 32'h00000000;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        ctx[0] <= in_ctx;
        dat[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          ctx[i] <= ctx[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_ctx   = ctx[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/pcileech_bar_regfile.sv
// BAR register file: writable registers with write/W1C masks, runtime init port,
// a 64-bit timestamp with latched high word, and a fixed-latency read pipeline.
module pcileech_bar_regfile
  import pcileech_bar_pkg::*;
#(
  parameter int          NUM_REGS   = 64,
  parameter logic [31:0] ADDR_MASK  = 32'h0000FFFF,
  parameter int          RD_LATENCY = 2,
  parameter int          TS_IDX     = 62,
  parameter logic [31:0] DEFAULT_RD = 32'h00000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 wr_addr,
  input  logic [3:0]                  wr_be,
  input  logic [31:0]                 wr_data,
  input  logic                        wr_valid,
  input  logic [CTX_W-1:0]            rd_req_ctx,
  input  logic [31:0]                 rd_req_addr,
  input  logic                        rd_req_valid,
  input  logic [31:0]                 base_address_register,
  input  logic                        init_valid,
  input  logic [$clog2(NUM_REGS)-1:0] init_idx,
  input  logic [31:0]                 init_data,
  input  logic [31:0]                 init_wmask,
  input  logic [31:0]                 init_w1cmask,
  output logic [CTX_W-1:0]            rd_rsp_ctx,
  output logic [31:0]                 rd_rsp_data,
  output logic                        rd_rsp_valid
);

  localparam int            IW    = $clog2(NUM_REGS);
  localparam logic [IW-1:0] TS_LO = IW'(TS_IDX);
  localparam logic [IW-1:0] TS_HI = IW'(TS_IDX + 1);

  reg_entry_t       regs [NUM_REGS];
  logic [63:0]      ts_count;
  logic [31:0]      ts_hi_latch;

  logic             rd_valid_q;
  logic [CTX_W-1:0] rd_ctx_q;
  logic [31:0]      rd_addr_q;
  logic             wr_valid_q;
  logic [3:0]       wr_be_q;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_data_q;

  logic             s1_valid;
  logic [CTX_W-1:0] s1_ctx;
  logic [31:0]      s1_data;

  logic [29:0]      rd_dw;
  logic [29:0]      wr_dw;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic             rd_hit;
  logic             wr_ok;
  logic [31:0]      sel_data;

  // Reads and writes are decoded in the same cycle, so a colliding read sees pre-write data.
  always_comb begin
    rd_dw    = bar_dword(rd_addr_q, base_address_register, ADDR_MASK);
    wr_dw    = bar_dword(wr_addr_q, base_address_register, ADDR_MASK);
    rd_idx   = rd_dw[IW-1:0];
    wr_idx   = wr_dw[IW-1:0];
    rd_hit   = rd_dw < 30'(NUM_REGS);
    wr_ok    = wr_valid_q && (wr_dw < 30'(NUM_REGS)) && (wr_idx != TS_LO) && (wr_idx != TS_HI);
    sel_data = DEFAULT_RD;
    if (rd_hit) begin
      if (rd_idx == TS_LO) sel_data = ts_count[31:0];
      else if (rd_idx == TS_HI) sel_data = ts_hi_latch;
      else sel_data = regs[rd_idx].value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req_valid;
      wr_valid_q <= wr_valid;
      if (rd_req_valid) begin
        rd_ctx_q  <= rd_req_ctx;
        rd_addr_q <= rd_req_addr;
      end
      if (wr_valid) begin
        wr_addr_q <= wr_addr;
        wr_be_q   <= wr_be;
        wr_data_q <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_ctx      <= '0;
      s1_data     <= 32'h00000000;
      ts_count    <= 64'h0;
      ts_hi_latch <= 32'h00000000;
    end else begin
      s1_valid <= rd_valid_q;
      if (rd_valid_q) begin
        s1_ctx  <= rd_ctx_q;
        s1_data <= sel_data;
      end
      if (rd_valid_q && rd_hit && rd_idx == TS_LO) ts_hi_latch <= ts_count[63:32];
      if (init_valid && init_idx == TS_LO) ts_count <= {ts_count[63:32] + {31'h0, &ts_count[31:0]}, init_data};
      else if (init_valid && init_idx == TS_HI) ts_count <= {init_data, ts_count[31:0] + 32'h1};
      else ts_count <= ts_count + 64'h1;
    end
  end

  // The init assignment comes last so it overrides a host write to the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i].value <= regs[i].shadow;
    end else begin
      if (wr_ok)
        regs[wr_idx].value <= merge_write(regs[wr_idx].value, regs[wr_idx].wmask,
                                          regs[wr_idx].w1cmask, wr_be_q, wr_data_q);
      if (init_valid) regs[init_idx] <= '{init_data, init_data, init_wmask, init_w1cmask};
    end
  end

  if (RD_LATENCY > 2) begin : g_delay
    pcileech_bar_rdpipe #(.DEPTH(RD_LATENCY - 2)) u_rdpipe (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s1_valid),
      .in_ctx   (s1_ctx),
      .in_data  (s1_data),
      .out_valid(rd_rsp_valid),
      .out_ctx  (rd_rsp_ctx),
      .out_data (rd_rsp_data)
    );
  end else begin : g_direct
    assign rd_rsp_valid = s1_valid;
    assign rd_rsp_ctx   = s1_ctx;
    assign rd_rsp_data  = s1_data;
  end

endmodule

// File: tb/tb_pcileech_bar_regfile.sv
// Randomized bench for pcileech_bar_regfile against a dword-array reference model
// with an expected-response queue, plus directed scenarios.
module tb_pcileech_bar_regfile;

  localparam int          NUM_REGS   = 64;
  localparam logic [31:0] ADDR_MASK  = 32'h0000FFFF;
  localparam int          RD_LATENCY = 2;
  localparam int          TS_IDX     = 62;
  localparam logic [31:0] DEFAULT_RD = 32'hBADC0DE5;
  localparam logic [31:0] BAR        = 32'hF7E00004;
  localparam logic [31:0] BAR_EFF    = BAR & ~32'h00000004;
  localparam int          IW         = $clog2(NUM_REGS);

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   wr_addr, wr_data, rd_req_addr, init_data, init_wmask, init_w1cmask;
  logic [3:0]    wr_be;
  logic          wr_valid, rd_req_valid, init_valid;
  logic [87:0]   rd_req_ctx, rd_rsp_ctx;
  logic [IW-1:0] init_idx;
  logic [31:0]   rd_rsp_data;
  logic          rd_rsp_valid;

  always #5 clk = ~clk;

  pcileech_bar_regfile #(
    .NUM_REGS(NUM_REGS), .ADDR_MASK(ADDR_MASK), .RD_LATENCY(RD_LATENCY),
    .TS_IDX(TS_IDX), .DEFAULT_RD(DEFAULT_RD)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
    .base_address_register(BAR),
    .init_valid(init_valid), .init_idx(init_idx), .init_data(init_data),
    .init_wmask(init_wmask), .init_w1cmask(init_w1cmask),
    .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    int          due;
    logic [87:0] ctx;
    logic [31:0] data;
  } exp_t;

  logic [31:0] m_val [NUM_REGS] = '{default: 32'h0};
  logic [31:0] m_shd [NUM_REGS] = '{default: 32'h0};
  logic [31:0] m_wm  [NUM_REGS] = '{default: 32'h0};
  logic [31:0] m_w1c [NUM_REGS] = '{default: 32'h0};
  logic [63:0] m_ts = 64'h0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_last = 32'h0;
  exp_t        expq[$];
  int          edge_n = 0;
  logic        pr_v = 1'b0, pw_v = 1'b0;
  logic [31:0] pr_addr, pw_addr, pw_data;
  logic [87:0] pr_ctx;
  logic [3:0]  pw_be;
  int          pr_n;

  function automatic int dword_of(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BAR_EFF) & ADDR_MASK;
    return int'(off / 4);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] cur, input logic [31:0] wm,
                                          input logic [31:0] w1c, input logic [3:0] be,
                                          input logic [31:0] d);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 32; b++) begin
      if (be[b/8]) begin
        if (w1c[b]) begin
          if (d[b]) r[b] = 1'b0;
        end else if (wm[b]) r[b] = d[b];
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    int   idx;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) m_val[i] = m_shd[i];
      m_ts = 64'h0; m_hi = 32'h0; m_last = 32'h0;
      pr_v = 1'b0; pw_v = 1'b0;
      expq.delete();
      return;
    end
    if (pr_v) begin
      idx = dword_of(pr_addr);
      if (idx >= NUM_REGS) e.data = DEFAULT_RD;
      else if (idx == TS_IDX) begin e.data = m_ts[31:0]; m_hi = m_ts[63:32]; end
      else if (idx == TS_IDX + 1) e.data = m_hi;
      else e.data = m_val[idx];
      e.due = pr_n + RD_LATENCY - 1;
      e.ctx = pr_ctx;
      expq.push_back(e);
    end
    if (pw_v) begin
      idx = dword_of(pw_addr);
      if (idx < NUM_REGS && idx != TS_IDX && idx != TS_IDX + 1)
        m_val[idx] = m_merge(m_val[idx], m_wm[idx], m_w1c[idx], pw_be, pw_data);
    end
    m_ts = m_ts + 64'h1;
    if (init_valid) begin
      m_val[init_idx] = init_data; m_shd[init_idx] = init_data;
      m_wm[init_idx] = init_wmask; m_w1c[init_idx] = init_w1cmask;
      if (int'(init_idx) == TS_IDX) m_ts[31:0] = init_data;
      else if (int'(init_idx) == TS_IDX + 1) m_ts[63:32] = init_data;
    end
    pr_v = rd_req_valid; pr_addr = rd_req_addr; pr_ctx = rd_req_ctx; pr_n = edge_n;
    pw_v = wr_valid; pw_addr = wr_addr; pw_be = wr_be; pw_data = wr_data;
  endtask

  task automatic check_outputs();
    if (expq.size() > 0 && expq[0].due == edge_n) begin
      chk("rsp_valid", rd_rsp_valid, 1'b1);
      chk("rsp_ctx", rd_rsp_ctx, expq[0].ctx);
      chk("rsp_data", rd_rsp_data, expq[0].data);
      m_last = expq[0].data;
      void'(expq.pop_front());
    end else begin
      chk("idle_valid", rd_rsp_valid, 1'b0);
      chk("hold_data", rd_rsp_data, m_last);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_init(input int idx, input logic [31:0] d, input logic [31:0] wm, input logic [31:0] w1c);
    init_valid = 1'b1; init_idx = IW'(idx); init_data = d; init_wmask = wm; init_w1cmask = w1c;
    step();
    init_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] off, input logic [3:0] be, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = BAR_EFF + off; wr_be = be; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] off, input logic [87:0] ctx);
    rd_req_valid = 1'b1; rd_req_addr = BAR_EFF + off; rd_req_ctx = ctx;
    step();
    rd_req_valid = 1'b0;
  endtask

  // Issues one read and waits (bounded) for its response; checks data and latency.
  task automatic rd_expect(input string tag, input logic [31:0] off, input logic [31:0] exp);
    int lat;
    do_read(off, {24'hA11CE0, off, 32'h5EED0001});
    lat = 1;
    do begin
      step();
      lat++;
    end while (!rd_rsp_valid && lat < 8);
    chk({tag, "_data"}, rd_rsp_data, exp);
    chk({tag, "_lat"}, 88'(lat), 88'(RD_LATENCY));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] off;
    if ($urandom_range(0, 9) == 0) off = $urandom_range(NUM_REGS * 4, 32'h0000FFFF);
    else off = $urandom_range(0, NUM_REGS * 4 - 1);
    return BAR_EFF + off + ($urandom << 16);
  endfunction

  initial begin
    int          seen;
    int          offs [8] = '{0, 4, 8, 32'h1000, 12, 16, 20, 24};
    logic [31:0] wm;
    rst = 1'b1; wr_valid = 1'b0; rd_req_valid = 1'b0; init_valid = 1'b0;
    wr_addr = 32'h0; wr_be = 4'h0; wr_data = 32'h0; rd_req_addr = 32'h0; rd_req_ctx = 88'h0;
    init_idx = '0; init_data = 32'h0; init_wmask = 32'h0; init_w1cmask = 32'h0;
    repeat (3) step();
    chk("rst_valid", rd_rsp_valid, 1'b0);
    chk("rst_data", rd_rsp_data, 32'h0);
    chk("rst_ctx", rd_rsp_ctx, 88'h0);
    rst = 1'b0;

    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != TS_IDX && i != TS_IDX + 1) begin
        wm = $urandom;
        do_init(i, $urandom, wm, wm & $urandom);
      end
    end

    // Read-only register ignores host writes
    do_init(5, 32'h00800000, 32'h0, 32'h0);
    do_write(32'h14, 4'hF, 32'hFFFFFFFF);
    rd_expect("t1_ro", 32'h14, 32'h00800000);

    // Byte-lane write
    do_init(3, 32'h0, 32'h0000FFFF, 32'h0);
    do_write(32'h0C, 4'b0001, 32'h12345678);
    rd_expect("t2_be", 32'h0C, 32'h00000078);

    // Write-1-to-clear
    do_init(7, 32'h000000F0, 32'h000000F0, 32'h000000F0);
    do_write(32'h1C, 4'hF, 32'h00000030);
    rd_expect("t3_w1c", 32'h1C, 32'h000000C0);

    // Timestamp: low read at 1_FFFFFFFE latches the high word
    do_init(TS_IDX + 1, 32'h00000001, 32'h0, 32'h0);
    do_init(TS_IDX, 32'hFFFFFFFD, 32'h0, 32'h0);
    rd_expect("t4_ts_lo", TS_IDX * 4, 32'hFFFFFFFE);
    repeat (10) step();
    rd_expect("t4_ts_hi", (TS_IDX + 1) * 4, 32'h00000001);

    // Back-to-back reads, in-order with ctx echo, one out of range
    for (int i = 0; i < 8; i++) begin
      rd_req_valid = 1'b1; rd_req_addr = BAR_EFF + offs[i];
      rd_req_ctx = {24'hC7C7C7, 32'(i), $urandom};
      step();
    end
    rd_req_valid = 1'b0;
    repeat (3) step();
    rd_expect("t5_oor", 32'h1000, DEFAULT_RD);

    // Reset with reads in flight; register returns to its shadow
    do_init(10, 32'h00000011, 32'hFFFFFFFF, 32'h0);
    do_write(32'h28, 4'hF, 32'h000000A5);
    rd_expect("t6_pre", 32'h28, 32'h000000A5);
    do_read(32'h28, 88'h1);
    rst = 1'b1; rd_req_valid = 1'b1; rd_req_ctx = 88'h2;
    seen = 0;
    step();
    rd_req_valid = 1'b0;
    if (rd_rsp_valid) seen++;
    step();
    if (rd_rsp_valid) seen++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rd_rsp_valid) seen++;
    end
    chk("t6_flush", 88'(seen), 88'h0);
    rd_expect("t6_shadow", 32'h28, 32'h00000011);

    // Randomized traffic, including read/write collisions, init and occasional reset
    for (int c = 0; c < 1500; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      rd_req_valid = $urandom_range(0, 1) == 1;
      rd_req_addr  = rand_addr();
      rd_req_ctx   = {24'($urandom), $urandom, $urandom};
      wr_valid     = $urandom_range(0, 9) < 4;
      wr_addr      = ($urandom_range(0, 3) == 0) ? rd_req_addr : rand_addr();
      wr_be        = 4'($urandom);
      wr_data      = $urandom;
      init_valid   = $urandom_range(0, 24) == 0;
      init_idx     = IW'($urandom_range(0, NUM_REGS - 1));
      init_data    = $urandom;
      init_wmask   = $urandom;
      init_w1cmask = init_wmask & $urandom;
      step();
    end
    rst = 1'b0; rd_req_valid = 1'b0; wr_valid = 1'b0; init_valid = 1'b0;
    repeat (5) step();
    chk("drain_empty", 88'(expq.size()), 88'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
